// File: rtl/frac_clk_gen_pkg.sv
// Shared types and helpers for the rational clock-enable generator.
package frac_clk_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam int unsigned DEF_NUM_RST = 1007;
    localparam int unsigned DEF_DEN_RST = 2000;

    // A ratio is usable when it never asks for more than one tick per cycle.
    function automatic logic is_legal_ratio(input logic [31:0] num, input logic [31:0] den);
        return (den != 32'd0) && (num <= den);
    endfunction

endpackage

// File: rtl/frac_clk_gen_if.sv
// Ratio configuration handshake between a controller and frac_clk_gen.
interface frac_clk_gen_if #(parameter int ACC_W = 16);

    logic [ACC_W-1:0] cfg_num;
    logic [ACC_W-1:0] cfg_den;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (output cfg_num, cfg_den, cfg_valid, input cfg_ready, cfg_err);
    modport slave  (input cfg_num, cfg_den, cfg_valid, output cfg_ready, cfg_err);

endinterface

// File: rtl/frac_clk_gen_acc.sv
// Phase accumulator: adds num each enabled cycle, subtracts den and registers a tick on wrap.
module frac_clk_acc #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [ACC_W-1:0] num,
    input  logic [ACC_W-1:0] den,
    output logic             hit,
    output logic             tick
);

    // One spare bit so acc + num never overflows before the compare.
    logic [ACC_W:0] acc;
    logic [ACC_W:0] s;

    assign s   = acc + {1'b0, num};
    assign hit = en && (s >= {1'b0, den});

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= hit;
            if (clr)
                acc <= '0;
            else if (en)
                acc <= hit ? (s - {1'b0, den}) : s;
        end
    end

endmodule

// File: rtl/frac_clk_gen.sv
// Rational clock-enable generator: tick at f_clk*NUM/DEN, clk_out at half that rate.
// Optional FRAC_CLK_GEN_STATS_EN adds tick_cnt and apply_cnt outputs.
module frac_clk_gen
    import frac_clk_pkg::*;
#(
    parameter int          ACC_W   = 16,
    parameter int unsigned NUM_RST = DEF_NUM_RST,
    parameter int unsigned DEN_RST = DEF_DEN_RST
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    frac_clk_gen_if.slave cfg,
    output logic          tick,
    output logic          clk_out,
    output logic          cfg_pending
`ifdef FRAC_CLK_GEN_STATS_EN
    ,
    output logic [31:0]   tick_cnt,
    output logic [7:0]    apply_cnt
`endif
);

    state_t           state;
    logic [ACC_W-1:0] num_q;
    logic [ACC_W-1:0] den_q;
    logic [ACC_W-1:0] sh_num;
    logic [ACC_W-1:0] sh_den;
    logic             hit;
    logic             take;
    logic             legal;
    logic             apply;

    assign take  = cfg.cfg_valid && cfg.cfg_ready;
    assign legal = is_legal_ratio(32'(cfg.cfg_num), 32'(cfg.cfg_den));
    // num==0 never ticks, so it escapes straight to the apply; en=0 still holds it off.
    assign apply = (state == PEND) && en && (hit || (num_q == '0));

    frac_clk_acc #(.ACC_W(ACC_W)) u_acc (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (apply),
        .num  (num_q),
        .den  (den_q),
        .hit  (hit),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            num_q         <= ACC_W'(NUM_RST);
            den_q         <= ACC_W'(DEN_RST);
            sh_num        <= '0;
            sh_den        <= '0;
            cfg.cfg_ready <= 1'b1;
            cfg.cfg_err   <= 1'b0;
            cfg_pending   <= 1'b0;
            clk_out       <= 1'b0;
        end else begin
            cfg.cfg_err <= take && !legal;
            if (hit)
                clk_out <= ~clk_out;
            case (state)
                RUN: begin
                    if (take && legal) begin
                        sh_num        <= cfg.cfg_num;
                        sh_den        <= cfg.cfg_den;
                        state         <= PEND;
                        cfg.cfg_ready <= 1'b0;
                        cfg_pending   <= 1'b1;
                    end
                end
                PEND: begin
                    if (apply) begin
                        num_q         <= sh_num;
                        den_q         <= sh_den;
                        state         <= RUN;
                        cfg.cfg_ready <= 1'b1;
                        cfg_pending   <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef FRAC_CLK_GEN_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            apply_cnt <= '0;
        end else begin
            if (hit)
                tick_cnt <= tick_cnt + 32'd1;
            if (apply && (apply_cnt != 8'hFF))
                apply_cnt <= apply_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frac_clk_gen.sv
// Self-checking bench for frac_clk_gen; reference model counts ticks as floor(k*num/den).
// Connects the FRAC_CLK_GEN_STATS_EN ports when that macro is defined.
module tb_frac_clk_gen;

    typedef struct {
        bit        v;
        int        n;
        int        d;
        bit        e_tick;
        bit        e_err;
        bit        e_ready;
        bit        e_pend;
    } vec_t;

    logic clk;
    logic rst;
    logic en;
    logic tick;
    logic clk_out;
    logic cfg_pending;
`ifdef FRAC_CLK_GEN_STATS_EN
    logic [31:0] tick_cnt;
    logic [7:0]  apply_cnt;
`endif

    frac_clk_gen_if #(.ACC_W(16)) cfg_if ();

    frac_clk_gen #(.ACC_W(16), .NUM_RST(1007), .DEN_RST(2000)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg         (cfg_if),
        .tick        (tick),
        .clk_out     (clk_out),
        .cfg_pending (cfg_pending)
`ifdef FRAC_CLK_GEN_STATS_EN
        ,
        .tick_cnt    (tick_cnt),
        .apply_cnt   (apply_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: k enabled cycles since the phase origin, ticks so far = floor(k*num/den).
    longint m_num, m_den, m_k, m_sh_num, m_sh_den;
    bit     m_tick, m_clk, m_err, m_pend;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint m_acc();
        return (m_k * m_num) % m_den;
    endfunction

    task automatic check_all();
        chk("tick", tick, m_tick);
        chk("clk_out", clk_out, m_clk);
        chk("cfg_ready", cfg_if.cfg_ready, !m_pend);
        chk("cfg_pending", cfg_pending, m_pend);
        chk("cfg_err", cfg_if.cfg_err, m_err);
        chk("acc", dut.u_acc.acc, m_acc());
    endtask

    task automatic cycle(input bit e, input bit v, input int n, input int d);
        bit hit, legal, take, apply;
        en = e;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_num = 16'(n);
        cfg_if.cfg_den = 16'(d);
        hit   = e && (m_num != 0) && (((m_k + 1) * m_num) / m_den > (m_k * m_num) / m_den);
        legal = (d != 0) && (n <= d);
        take  = v && !m_pend;
        apply = m_pend && e && (hit || m_num == 0);
        m_tick = hit;
        if (hit) m_clk = ~m_clk;
        m_err = take && !legal;
        if (apply) begin
            m_num = m_sh_num; m_den = m_sh_den; m_k = 0; m_pend = 0;
        end else if (e) begin
            m_k++;
        end
        if (take && legal) begin
            m_pend = 1; m_sh_num = n; m_sh_den = d;
        end
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic do_reset(input bit v, input int n, input int d);
        rst = 1'b1;
        en = 1'b1;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_num = 16'(n);
        cfg_if.cfg_den = 16'(d);
        @(posedge clk); #1;
        rst = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        m_num = 1007; m_den = 2000; m_k = 0;
        m_tick = 0; m_clk = 0; m_err = 0; m_pend = 0;
        check_all();
        chk("rst_num", dut.num_q, 1007);
        chk("rst_den", dut.den_q, 2000);
    endtask

    task automatic wait_apply();
        for (int i = 0; i < 20 && m_pend; i++) cycle(1, 0, 0, 0);
        chk("apply_timeout", m_pend, 0);
    endtask

    vec_t tbl[10];

    initial begin
        longint frz;
        int     ticks, toggles, bad_gap, last, prev_clk;

        tbl[0] = '{1, 5, 4, 0, 1, 1, 0};
        tbl[1] = '{1, 3, 0, 1, 1, 1, 0};
        tbl[2] = '{0, 0, 0, 0, 0, 1, 0};
        tbl[3] = '{1, 1, 4, 1, 0, 0, 1};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 1};
        tbl[5] = '{0, 0, 0, 1, 0, 1, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 1, 0};
        tbl[7] = '{0, 0, 0, 0, 0, 1, 0};
        tbl[8] = '{0, 0, 0, 0, 0, 1, 0};
        tbl[9] = '{0, 0, 0, 1, 0, 1, 0};

        rst = 1'b1; en = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_num = '0; cfg_if.cfg_den = '0;

        // Default ratio over 20000 cycles.
        do_reset(0, 0, 0);
        ticks = 0; toggles = 0; bad_gap = 0; last = -1; prev_clk = 0;
        for (int c = 0; c < 20000; c++) begin
            cycle(1, 0, 0, 0);
            if (tick) begin
                ticks++;
                if (last >= 0 && (c - last < 1 || c - last > 2)) bad_gap++;
                last = c;
            end
            if (clk_out != prev_clk) toggles++;
            prev_clk = clk_out;
        end
        chk("ticks_20000", ticks, 10070);
        chk("toggles_20000", toggles, 10070);
        chk("tick_gap", bad_gap, 0);

        // Handshake table from reset: rejects, then 1/4 accepted alongside a tick.
        do_reset(0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, tbl[i].v, tbl[i].n, tbl[i].d);
            chk($sformatf("tbl%0d_tick", i), tick, tbl[i].e_tick);
            chk($sformatf("tbl%0d_err", i), cfg_if.cfg_err, tbl[i].e_err);
            chk($sformatf("tbl%0d_ready", i), cfg_if.cfg_ready, tbl[i].e_ready);
            chk($sformatf("tbl%0d_pend", i), cfg_pending, tbl[i].e_pend);
        end
        chk("num_after_tbl", dut.num_q, 1);
        chk("den_after_tbl", dut.den_q, 4);

        // 4/4 ticks every cycle.
        cycle(1, 1, 4, 4);
        wait_apply();
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0, 0);
            chk("full_rate_tick", tick, 1);
        end
        // 0/7 stops ticks.
        cycle(1, 1, 0, 7);
        wait_apply();
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0, 0);
            chk("zero_tick", tick, 0);
            chk("zero_acc", dut.u_acc.acc, 0);
        end
        // 1/2 via the num==0 escape, then alternating.
        cycle(1, 1, 1, 2);
        chk("esc_pend_set", cfg_pending, 1);
        cycle(1, 0, 0, 0);
        chk("esc_applied", cfg_pending, 0);
        chk("esc_num", dut.num_q, 1);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 0, 0);
            chk("half_tick", tick, i % 2);
        end

        // 1/3 with en dropped for 50 cycles.
        cycle(1, 1, 1, 3);
        wait_apply();
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        frz = m_acc();
        for (int i = 0; i < 50; i++) begin
            cycle(0, 0, 0, 0);
            chk("frozen_tick", tick, 0);
            chk("frozen_acc", dut.u_acc.acc, frz);
        end
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0);

        // Reset while 1/8 is pending, with a request on the reset cycle.
        cycle(1, 1, 1, 8);
        chk("pend_before_rst", cfg_pending, 1);
        do_reset(1, 2, 5);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        chk("num_after_rst", dut.num_q, 1007);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                  int'($urandom_range(0, 22)), int'($urandom_range(0, 20)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frac_clk_gen.md
Name: frac_clk_gen

Overview:
- Parametrised rational clock-enable generator; next generation of the VGA pixel-clock divider.
- Produces an exact average tick rate of f_clk*NUM/DEN using a phase accumulator. Example: 50 MHz input with 1007/2000 gives 25.175 MHz.
- Emits a 1-cycle tick enable for downstream timing logic and a toggled clk_out at half the tick rate.
- NUM and DEN are runtime-reprogrammable via a valid/ready handshake; a new ratio is applied glitch-free at the next tick boundary.

Parameters:
- ACC_W, 16, width of NUM, DEN and the accumulator (max DEN = 2^ACC_W-1).
- NUM_RST, 1007, ratio numerator loaded at reset.
- DEN_RST, 2000, ratio denominator loaded at reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  run enable; low freezes the accumulator and suppresses tick.
- cfg_num  in  ACC_W  requested numerator.
- cfg_den  in  ACC_W  requested denominator.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  high when a request can be accepted.
- cfg_err  out  1  1-cycle pulse when a request is rejected.
- tick  out  1  1-cycle enable at rate f_clk*NUM/DEN.
- clk_out  out  1  toggles on every tick.
- cfg_pending  out  1  an accepted config awaits its apply point.

Behaviour:
- Reset: acc=0, num=NUM_RST, den=DEN_RST, tick=0, clk_out=0, cfg_ready=1, cfg_err=0, cfg_pending=0, state=RUN.
- Reset wins over every other input in the same cycle, including mid-pending config; the pending config is discarded.
- Accumulator (ACC_W+1 bits internally, no overflow):
  - Each cycle with en=1: s = acc + num.
  - If s >= den: acc <= s - den and tick <= 1 (registered, 1-cycle latency from the accumulating edge).
  - Else: acc <= s and tick <= 0.
  - With en=0: acc holds and tick=0. clk_out holds its level.
- clk_out <= ~clk_out in the same cycle tick is asserted.
- Legal ratio: den != 0 and num <= den.
  - num == den gives tick every enabled cycle.
  - num == 0 gives no ticks and the accumulator stays 0.
- Handshake: transfer when cfg_valid && cfg_ready.
  - Illegal ratio: request is consumed, cfg_err pulses the next cycle, and the state is unchanged.
  - Legal ratio: values are captured into shadow registers.
- States:
  - RUN: cfg_ready=1. A legal transfer moves to PEND.
  - PEND: cfg_ready=0, cfg_pending=1.
    - On the cycle a tick is generated (s >= den with en=1), or on any cycle while num==0 (escape path), shadow copies to num/den and acc <= 0; go to RUN.
    - With en=0, PEND waits indefinitely.
- Simultaneous tick and legal transfer in RUN: accept into shadow; the apply happens at the following tick, not the current one.
- Ratio accuracy: over any window of DEN enabled cycles at a fixed ratio, exactly NUM ticks; tick spacing is floor or ceil of DEN/NUM.

Optional Feature:
- Macro: FRAC_CLK_GEN_STATS_EN.
- Defined:
  - Adds output tick_cnt [31:0]: free-running count of ticks, reset to 0, wraps 0xFFFFFFFF->0.
  - Adds output apply_cnt [7:0]: count of applied configs, saturating at 255.
- Undefined: neither port nor its logic exists; remaining behaviour is identical.

Decomposition:
- Shared package frac_clk_pkg holds:
  - the state enum {RUN, PEND};
  - default constants NUM_RST/DEN_RST;
  - a function is_legal_ratio(num, den).
- One sub-module, frac_clk_acc: accumulator, compare/subtract and tick register, with inputs num, den, en and clr.
- The top module owns the handshake, the shadow registers, the FSM and clk_out.

Test Plan:
- Reset defaults 1007/2000, en=1, 20000 cycles -> exactly 10070 ticks; clk_out toggles 10070 times; spacing is only 1 or 2 cycles.
- cfg 1/4 legal while running -> cfg_pending=1 until the next tick; then ticks every 4 cycles exactly; cfg_ready returns high the cycle after apply.
- cfg 5/4 and cfg 3/0 -> cfg_err pulses once each; the ratio is unchanged; cfg_ready stays 1.
- cfg 4/4 -> tick high every enabled cycle; then cfg 0/7 -> ticks stop and acc=0; then cfg 1/2 -> applied on the very next cycle via the num==0 escape, then alternating ticks.
- en dropped for 50 cycles mid-sequence with 1/3 -> no ticks and acc frozen; resumption continues the exact phase (next tick at the same residual offset).
- Assert rst during PEND with 1/8 pending -> next cycle num=1007, den=2000, cfg_pending=0, acc=0, clk_out=0.
